// File: rtl/sample_count_ctrl_if.sv
// Byte-load handshake between the UART byte stream and the acquisition-length controller.
// No storage of its own; it only bundles the valid/byte/ready signals.
// Backpressure: the slave deasserts load_ready while a run is in progress.
//   load_valid  master->slave  byte available
//   load_byte   master->slave  count byte, LSB-first
//   load_ready  slave->master  controller accepts bytes
interface sample_count_ctrl_if;
    logic       load_valid;
    logic [7:0] load_byte;
    logic       load_ready;

    modport master (output load_valid, output load_byte, input load_ready);
    modport slave  (input load_valid, input load_byte, output load_ready);
endinterface

// File: rtl/sample_count_ctrl.sv
// Acquisition-length controller: byte-loaded target, arm/run/done FSM, decimated sample counting.
// Latency: all status outputs are registered; done/done_pulse appear the cycle after the final strobe.
// Backpressure: load_ready is low in RUN; bytes are accepted only in IDLE or DONE.
//   clk, rst             clock, synchronous active-high reset
//   ld                   byte-load handshake (slave side)
//   start, abort         single-cycle arm/run and cancel requests
//   en, decim            sample strobe and decimation ratio (count one per decim+1 strobes)
//   busy, done           state is RUN / state is DONE
//   done_pulse           one cycle on entry to DONE
//   start_err            one cycle after a rejected start
//   remaining, target    samples still to count, committed target
module sample_count_ctrl #(
    parameter int              COUNT_W   = 32,
    parameter longint unsigned DEFAULT_N = 64'd5000000,
    parameter int              DECIM_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    sample_count_ctrl_if.slave  ld,
    input  logic                start,
    input  logic                abort,
    input  logic                en,
    input  logic [DECIM_W-1:0]  decim,
    output logic                busy,
    output logic                done,
    output logic                done_pulse,
    output logic                start_err,
    output logic [COUNT_W-1:0]  remaining,
    output logic [COUNT_W-1:0]  target
);
    localparam int NBYTES = COUNT_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   target_q, target_d;
    logic [COUNT_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [COUNT_W-1:0]   remaining_q, remaining_d;
    logic [DECIM_W-1:0]   decim_cnt_q, decim_cnt_d;
    logic [DECIM_W-1:0]   decim_lat_q, decim_lat_d;
    logic                 done_pulse_q, done_pulse_d;
    logic                 start_err_q, start_err_d;

    logic                 load_acc;
    logic [COUNT_W+7:0]   shift_cat;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        shadow_d     = shadow_q;
        byte_idx_d   = byte_idx_q;
        remaining_d  = remaining_q;
        decim_cnt_d  = decim_cnt_q;
        decim_lat_d  = decim_lat_q;
        done_pulse_d = 1'b0;
        start_err_d  = 1'b0;

        load_acc  = ld.load_valid && (state_q != S_RUN);
        // New byte enters at the top; after NBYTES bytes the first one sits in the LSBs.
        shift_cat = {ld.load_byte, shadow_q};

        if (abort) begin
            // A byte offered alongside abort is dropped; target survives.
            state_d     = S_IDLE;
            remaining_d = '0;
            byte_idx_d  = '0;
            decim_cnt_d = '0;
        end else begin
            if (load_acc) begin
                shadow_d = shift_cat[COUNT_W+7:8];
                if (byte_idx_q == LAST_IDX) begin
                    byte_idx_d = '0;
                    target_d   = shift_cat[COUNT_W+7:8];
                end else begin
                    byte_idx_d = byte_idx_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Refuse to arm on an empty target or while a load is half-done or in flight.
                        if ((target_q == '0) || (byte_idx_q != '0) || load_acc) begin
                            start_err_d = 1'b1;
                        end else begin
                            state_d     = S_RUN;
                            remaining_d = target_q;
                            decim_lat_d = decim;
                            decim_cnt_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (decim_cnt_q == decim_lat_q) begin
                            decim_cnt_d = '0;
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == COUNT_W'(1)) begin
                                state_d      = S_DONE;
                                done_pulse_d = 1'b1;
                            end
                        end else begin
                            decim_cnt_d = decim_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            target_q     <= COUNT_W'(DEFAULT_N);
            shadow_q     <= '0;
            byte_idx_q   <= '0;
            remaining_q  <= '0;
            decim_cnt_q  <= '0;
            decim_lat_q  <= '0;
            done_pulse_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            shadow_q     <= shadow_d;
            byte_idx_q   <= byte_idx_d;
            remaining_q  <= remaining_d;
            decim_cnt_q  <= decim_cnt_d;
            decim_lat_q  <= decim_lat_d;
            done_pulse_q <= done_pulse_d;
            start_err_q  <= start_err_d;
        end
    end

    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign ld.load_ready = (state_q != S_RUN);
    assign done_pulse    = done_pulse_q;
    assign start_err     = start_err_q;
    assign remaining     = remaining_q;
    assign target        = target_q;
endmodule

// File: tb/tb_sample_count_ctrl.sv
// Bench for sample_count_ctrl: table vectors, hand-written corner sequences, random run vs reference model.
// A second 16-bit instance repeats the basic load/count sequence with two bytes.
// DEFAULT_N is shrunk so a full default-length run stays short.
module tb_sample_count_ctrl;
    localparam int              CW  = 32;
    localparam int              DW  = 8;
    localparam int              NB  = CW / 8;
    localparam longint unsigned DEF = 64'd300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, en;
    logic [DW-1:0] decim;
    logic          busy, done, done_pulse, start_err;
    logic [CW-1:0] remaining, target;
    sample_count_ctrl_if lif();

    sample_count_ctrl #(.COUNT_W(CW), .DEFAULT_N(DEF), .DECIM_W(DW)) dut (
        .clk(clk), .rst(rst), .ld(lif.slave), .start(start), .abort(abort), .en(en),
        .decim(decim), .busy(busy), .done(done), .done_pulse(done_pulse),
        .start_err(start_err), .remaining(remaining), .target(target)
    );

    logic          s_rst, s_start, s_abort, s_en;
    logic [DW-1:0] s_decim;
    logic          s_busy, s_done, s_done_pulse, s_start_err;
    logic [15:0]   s_remaining, s_target;
    sample_count_ctrl_if lif16();

    sample_count_ctrl #(.COUNT_W(16), .DEFAULT_N(DEF), .DECIM_W(DW)) dut16 (
        .clk(clk), .rst(s_rst), .ld(lif16.slave), .start(s_start), .abort(s_abort), .en(s_en),
        .decim(s_decim), .busy(s_busy), .done(s_done), .done_pulse(s_done_pulse),
        .start_err(s_start_err), .remaining(s_remaining), .target(s_target)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=done. Remaining is derived from strobes seen
    // since start, so decimation is plain integer division rather than a sub-counter.
    int              m_mode;
    longint unsigned m_target, m_run_tgt, m_strobes, m_d;
    logic [7:0]      m_q[$];
    bit              m_dp, m_se;

    function automatic void m_reset();
        m_mode = 0; m_target = DEF; m_q.delete();
        m_dp = 0; m_se = 0; m_strobes = 0; m_run_tgt = 0; m_d = 0;
    endfunction

    function automatic longint unsigned m_rem();
        return (m_mode == 1) ? m_run_tgt - m_strobes / (m_d + 1) : 64'd0;
    endfunction

    function automatic void m_step(input bit lv, input logic [7:0] b, input bit st,
                                   input bit ab, input bit e, input logic [7:0] d);
        bit acc = lv && (m_mode != 1);
        longint unsigned old_t = m_target;
        int old_n = m_q.size();
        m_dp = 0; m_se = 0;
        if (ab) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            if (acc) begin
                m_q.push_back(b);
                if (m_q.size() == NB) begin
                    m_target = 0;
                    for (int i = 0; i < NB; i++) m_target |= 64'(m_q[i]) << (8 * i);
                    m_q.delete();
                end
            end
            if (st && m_mode != 1) begin
                if (old_t == 0 || old_n != 0 || acc) m_se = 1;
                else begin
                    m_run_tgt = old_t; m_d = 64'(d); m_strobes = 0; m_mode = 1;
                end
            end else if (m_mode == 1 && e) begin
                m_strobes++;
                if (m_strobes == m_run_tgt * (m_d + 1)) begin
                    m_mode = 2; m_dp = 1;
                end
            end
        end
    endfunction

    // One clock with the given inputs, then compare every output against the model.
    task automatic cyc(input bit r, input bit lv, input logic [7:0] b, input bit st,
                       input bit ab, input bit e, input logic [7:0] d);
        rst = r; lif.load_valid = lv; lif.load_byte = b; start = st; abort = ab; en = e; decim = d;
        @(posedge clk);
        #1;
        if (r) m_reset();
        else m_step(lv, b, st, ab, e, d);
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_mode == 2);
        chk("done_pulse", done_pulse, m_dp);
        chk("start_err", start_err, m_se);
        chk("remaining", remaining, m_rem());
        chk("target", target, m_target);
        chk("load_ready", lif.load_ready, m_mode != 1);
    endtask

    task automatic load4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) cyc(0, 1, v[8*i +: 8], 0, 0, 0, 0);
    endtask

    // ctl = {rst, load_valid, start, abort, en}; xf = {busy, done, done_pulse, start_err, load_ready}
    typedef struct {
        logic [4:0]  ctl;
        logic [7:0]  b;
        logic [4:0]  xf;
        logic [31:0] xrem;
        logic [31:0] xtgt;
    } tvec_t;
    tvec_t tbl[$];

    task automatic cyc16(input bit r, input bit lv, input logic [7:0] b, input bit st, input bit e);
        s_rst = r; lif16.load_valid = lv; lif16.load_byte = b; s_start = st; s_abort = 0; s_en = e; s_decim = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; lif.load_valid = 0; lif.load_byte = 0; start = 0; abort = 0; en = 0; decim = 0;
        s_rst = 1; lif16.load_valid = 0; lif16.load_byte = 0; s_start = 0; s_abort = 0; s_en = 0; s_decim = 0;

        // ---------------- table vectors (decim = 0) ----------------
        tbl.push_back('{5'b10000, 8'h00, 5'b00001, 32'd0,  32'd300}); // reset
        tbl.push_back('{5'b01000, 8'h0A, 5'b00001, 32'd0,  32'd300}); // partial load
        tbl.push_back('{5'b01000, 8'h00, 5'b00001, 32'd0,  32'd300});
        tbl.push_back('{5'b01000, 8'h00, 5'b00001, 32'd0,  32'd300});
        tbl.push_back('{5'b01000, 8'h00, 5'b00001, 32'd0,  32'd10});  // commit on 4th byte
        tbl.push_back('{5'b00100, 8'h00, 5'b10000, 32'd10, 32'd10});  // start
        tbl.push_back('{5'b00001, 8'h00, 5'b10000, 32'd9,  32'd10});
        tbl.push_back('{5'b01001, 8'hFF, 5'b10000, 32'd8,  32'd10});  // load ignored in RUN
        tbl.push_back('{5'b00101, 8'h00, 5'b10000, 32'd7,  32'd10});  // start ignored in RUN
        tbl.push_back('{5'b00011, 8'h00, 5'b00001, 32'd0,  32'd10});  // abort beats en
        tbl.push_back('{5'b01000, 8'h03, 5'b00001, 32'd0,  32'd10});  // partial load
        tbl.push_back('{5'b00100, 8'h00, 5'b00011, 32'd0,  32'd10});  // start rejected
        tbl.push_back('{5'b00000, 8'h00, 5'b00001, 32'd0,  32'd10});  // err is one cycle
        tbl.push_back('{5'b00010, 8'h00, 5'b00001, 32'd0,  32'd10});  // abort clears byte_idx
        tbl.push_back('{5'b00100, 8'h00, 5'b10000, 32'd10, 32'd10});
        tbl.push_back('{5'b00001, 8'h00, 5'b10000, 32'd9,  32'd10});
        tbl.push_back('{5'b10000, 8'h00, 5'b00001, 32'd0,  32'd300}); // mid-run reset
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].ctl[4]; lif.load_valid = tbl[i].ctl[3]; start = tbl[i].ctl[2];
            abort = tbl[i].ctl[1]; en = tbl[i].ctl[0]; lif.load_byte = tbl[i].b; decim = 0;
            @(posedge clk);
            #1;
            chk("tbl_busy", busy, tbl[i].xf[4]);
            chk("tbl_done", done, tbl[i].xf[3]);
            chk("tbl_done_pulse", done_pulse, tbl[i].xf[2]);
            chk("tbl_start_err", start_err, tbl[i].xf[1]);
            chk("tbl_load_ready", lif.load_ready, tbl[i].xf[0]);
            chk("tbl_remaining", remaining, tbl[i].xrem);
            chk("tbl_target", target, tbl[i].xtgt);
        end

        // ---------------- default-length run ----------------
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 300; k++) cyc(0, 0, 0, 0, 0, 1, 0);
        chk("def_done_pulse", done_pulse, 1);
        chk("def_busy", busy, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("def_pulse_len", done_pulse, 0);
        chk("def_done_hold", done, 1);

        // ---------------- decimation: target 4, decim 2 ----------------
        cyc(1, 0, 0, 0, 0, 0, 0);
        load4(32'd4);
        cyc(0, 0, 0, 1, 0, 0, 2);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0, 0, 0, 0, 1, 8'($urandom_range(0, 9)));  // decim changes are ignored mid-run
            if (k < 12) chk("dec_remaining", remaining, 4 - k / 3);
        end
        chk("dec_done_pulse", done_pulse, 1);
        chk("dec_done", done, 1);

        // ---------------- zero target rejected ----------------
        cyc(1, 0, 0, 0, 0, 0, 0);
        load4(32'd0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("zero_start_err", start_err, 1);
        chk("zero_busy", busy, 0);

        // ---------------- abort mid-run ----------------
        load4(32'd100);
        cyc(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 0, 1, 0);
        chk("abt_remaining_pre", remaining, 60);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("abt_remaining", remaining, 0);
        chk("abt_no_pulse", done_pulse, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("abt_restart", remaining, 100);

        // ---------------- load in DONE with start on last byte ----------------
        cyc(1, 0, 0, 0, 0, 0, 0);
        load4(32'd2);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("dn_done", done, 1);
        cyc(0, 1, 8'h05, 0, 0, 0, 0);
        cyc(0, 1, 8'h00, 0, 0, 0, 0);
        cyc(0, 1, 8'h00, 0, 0, 0, 0);
        cyc(0, 1, 8'h00, 1, 0, 0, 0);
        chk("dn_target", target, 5);
        chk("dn_start_err", start_err, 1);
        chk("dn_still_done", done, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("dn_rerun", remaining, 5);
        chk("dn_busy", busy, 1);

        // ---------------- randomized run against the model ----------------
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit          r_lv, r_st, r_ab, r_e, r_r;
            logic [7:0]  r_b;
            r_lv = ($urandom_range(0, 3) == 0);
            r_b  = (m_q.size() == 0) ? 8'($urandom_range(0, 5))
                 : (($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
            r_st = ($urandom_range(0, 15) == 0);
            r_ab = ($urandom_range(0, 149) == 0);
            r_e  = ($urandom_range(0, 3) != 0);
            r_r  = ($urandom_range(0, 999) == 0);
            cyc(r_r, r_lv, r_b, r_st, r_ab, r_e, 8'($urandom_range(0, 2)));
        end

        // ---------------- 16-bit build: two-byte load, ten strobes ----------------
        cyc16(1, 0, 0, 0, 0);
        chk("w16_reset_target", s_target, 300);
        chk("w16_reset_ready", lif16.load_ready, 1);
        cyc16(0, 1, 8'h0A, 0, 0);
        chk("w16_partial", s_target, 300);
        cyc16(0, 1, 8'h00, 0, 0);
        chk("w16_target", s_target, 10);
        cyc16(0, 0, 0, 1, 0);
        chk("w16_busy", s_busy, 1);
        chk("w16_rem_start", s_remaining, 10);
        for (int k = 1; k <= 10; k++) begin
            cyc16(0, 0, 0, 0, 1);
            chk("w16_remaining", s_remaining, 10 - k);
            chk("w16_done_pulse", s_done_pulse, k == 10);
        end
        cyc16(0, 0, 0, 0, 0);
        chk("w16_pulse_len", s_done_pulse, 0);
        chk("w16_done", s_done, 1);
        chk("w16_err", s_start_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sample_count_ctrl.md
Name: sample_count_ctrl

Overview:
Parametrised acquisition-length controller for the correlator. It receives the sample count LSB-first from the UART byte stream through a valid/ready handshake and holds it in a committed target register. It counts sample strobes, with optional decimation, and flags completion. It adds an explicit arm/run/done state machine, abort, status readback and error reporting.

Parameters:
COUNT_W, 32, counter width in bits; multiple of 8, range 8..64; NBYTES = COUNT_W/8 (localparam)
DEFAULT_N, 5000000, target count loaded at reset
DECIM_W, 8, width of decimation ratio input

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_valid  in  1  UART byte available
load_byte  in  8  count byte, LSB-first
load_ready  out  1  controller accepts bytes (state IDLE or DONE)
start  in  1  arm/run request, single-cycle
abort  in  1  cancel, single-cycle
en  in  1  sample strobe
decim  in  DECIM_W  count one sample per decim+1 strobes
busy  out  1  state == RUN
done  out  1  level, high in DONE
done_pulse  out  1  one-cycle pulse on entry to DONE
start_err  out  1  one-cycle pulse, start rejected
remaining  out  COUNT_W  samples still to count
target  out  COUNT_W  committed target count

Behaviour:
- Reset values: state IDLE, target=DEFAULT_N, shadow=0, byte_idx=0, remaining=0, decim_cnt=0, decim_q=0. done, done_pulse, start_err and busy are 0; load_ready=1.
- Priority: rst > abort > load handshake > start > en.
- Load: a byte is accepted when load_valid & load_ready. On accept, shadow <= {load_byte, shadow[COUNT_W-1:8]} and byte_idx increments. On the NBYTES-th byte, target <= the shifted value in the same edge and byte_idx wraps to 0.
- A partial load leaves target unchanged. load_ready is 0 in RUN, and load_valid is ignored there.
- States are IDLE, RUN and DONE.
- IDLE/DONE + start, when none of the reject conditions holds: remaining <= target, decim_q <= decim, decim_cnt <= 0, go to RUN. done drops on the same edge.
- start is rejected, with a start_err pulse on the next cycle and the state unchanged, in any of these cases:
  - target == 0
  - byte_idx != 0 (partial load pending)
  - a load handshake occurs in the same cycle
- RUN + en: if decim_cnt == decim_q, then decim_cnt <= 0 and remaining <= remaining-1; otherwise decim_cnt++. en outside RUN is ignored.
- RUN: when the decrement takes remaining from 1 to 0, go to DONE on that edge. done=1 and done_pulse=1 are registered, visible the cycle after that en. done_pulse lasts exactly one cycle.
- RUN + start: ignored, no error.
- DONE: remaining=0 and done held until start (re-run with the current target) or abort.
- abort, any state: go to IDLE, remaining <= 0, byte_idx <= 0, decim_cnt <= 0. No done_pulse. target is kept.
- Mid-run rst: identical to power-on reset, with target back to DEFAULT_N.
- Arithmetic: remaining never underflows, because decrement happens only in RUN with remaining >= 1. decim_cnt is DECIM_W bits and compared against the latched decim_q, so changing decim mid-run has no effect.
- Compatibility: with decim=0 it counts exactly target strobes, matching the legacy single-shot counter.

Test Plan:
1. Reset, start, 5000000 en strobes (COUNT_W=32, decim=0) -> busy falls and done_pulse fires one cycle after strobe 5000000; remaining=0.
2. Load bytes 0x0A,0x00,0x00,0x00, then start, 10 strobes -> target=10; done after 10th strobe; remaining steps 10→0.
3. target=4, decim=2, en continuous -> remaining decrements every 3rd strobe; done after strobe 12.
4. Load 2 of 4 bytes, then start -> start_err pulse, state IDLE, target unchanged. Load 0x00 x4, then start -> start_err (target=0).
5. target=100, run 40 strobes, abort -> IDLE, remaining=0, no done_pulse. Then start -> remaining=100.
6. In DONE, load_valid held high with 4 bytes plus start on the same cycle as the last byte -> target updated, start_err=1. Next start -> RUN with the new target. COUNT_W=16 build repeats test 2 with 2 bytes.
